// File: rtl/priv_1_13_trap_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// priv_1_13_trap_arbiter_pkg
// Shared machine-mode types for the trap arbiter and its interrupt priority
// encoder.
// Contents:
//   IRQ_*            interrupt cause codes (also the bit positions in mip/mie)
//   priv_level_t     privilege level encoding (U=0, S=1, M=3)
//   arb_state_t      trap arbiter FSM states (IDLE/WAIT/COMMIT)
//   mip_from_irq()   maps the packed irq_src vector onto mip bit positions
// -----------------------------------------------------------------------------
package priv_1_13_trap_arbiter_pkg;

   localparam int unsigned IRQ_SSI = 1;
   localparam int unsigned IRQ_MSI = 3;
   localparam int unsigned IRQ_STI = 5;
   localparam int unsigned IRQ_MTI = 7;
   localparam int unsigned IRQ_SEI = 9;
   localparam int unsigned IRQ_MEI = 11;

   typedef enum logic [1:0] {
      PRIV_U    = 2'd0,
      PRIV_S    = 2'd1,
      PRIV_RSVD = 2'd2,
      PRIV_M    = 2'd3
   } priv_level_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_COMMIT = 2'd2
   } arb_state_t;

   // irq_src is packed as {meip, seip, mtip, stip, msip, ssip}; every other
   // mip bit is hardwired to zero.
   function automatic logic [15:0] mip_from_irq(input logic [5:0] irq);
      logic [15:0] m;
      m          = 16'h0000;
      m[IRQ_MEI] = irq[5];
      m[IRQ_SEI] = irq[4];
      m[IRQ_MTI] = irq[3];
      m[IRQ_STI] = irq[2];
      m[IRQ_MSI] = irq[1];
      m[IRQ_SSI] = irq[0];
      return m;
   endfunction

endpackage

// File: rtl/priv_1_13_trap_arbiter_intr_prio.sv
// -----------------------------------------------------------------------------
// priv_1_13_intr_prio
// Combinational interrupt enable / delegation filter and fixed-priority
// encoder.
// Ports:
//   curr_priv_level  in   current privilege level
//   mstatus_mie      in   global M-mode interrupt enable
//   mstatus_sie      in   global S-mode interrupt enable
//   mip              in   registered pending bits
//   mie              in   per-interrupt enables
//   mideleg          in   interrupt delegation mask (1 = handled in S-mode)
//   intr_en          out  per-bit "this interrupt may be taken now"
//   any_intr         out  at least one interrupt may be taken
//   intr_cause       out  cause code of the highest-priority takeable interrupt
//   intr_to_s        out  that interrupt targets S-mode
// -----------------------------------------------------------------------------
module priv_1_13_intr_prio
   import priv_1_13_trap_arbiter_pkg::*;
#(
   parameter int NUM_CAUSE_BITS = 5
) (
   input  logic [1:0]                curr_priv_level,
   input  logic                      mstatus_mie,
   input  logic                      mstatus_sie,
   input  logic [15:0]               mip,
   input  logic [15:0]               mie,
   input  logic [15:0]               mideleg,
   output logic [15:0]               intr_en,
   output logic                      any_intr,
   output logic [NUM_CAUSE_BITS-1:0] intr_cause,
   output logic                      intr_to_s
);

   priv_level_t priv;
   logic        m_glb_en;
   logic        s_glb_en;
   logic [3:0]  sel_idx;

   // M-targeted interrupts are always takeable below M and need MIE in M.
   // S-targeted (delegated) interrupts are never taken while in M.
   always_comb begin
      priv     = priv_level_t'(curr_priv_level);
      m_glb_en = (priv != PRIV_M) || mstatus_mie;
      s_glb_en = (priv == PRIV_U) || ((priv == PRIV_S) && mstatus_sie);
      intr_en  = mip & mie & ((~mideleg & {16{m_glb_en}}) |
                              ( mideleg & {16{s_glb_en}}));
   end

   // Fixed priority: MEI > MSI > MTI > SEI > SSI > STI.
   always_comb begin
      sel_idx = 4'd0;
      if (intr_en[IRQ_MEI])      sel_idx = 4'(IRQ_MEI);
      else if (intr_en[IRQ_MSI]) sel_idx = 4'(IRQ_MSI);
      else if (intr_en[IRQ_MTI]) sel_idx = 4'(IRQ_MTI);
      else if (intr_en[IRQ_SEI]) sel_idx = 4'(IRQ_SEI);
      else if (intr_en[IRQ_SSI]) sel_idx = 4'(IRQ_SSI);
      else if (intr_en[IRQ_STI]) sel_idx = 4'(IRQ_STI);

      any_intr   = |intr_en;
      intr_cause = NUM_CAUSE_BITS'(sel_idx);
      intr_to_s  = any_intr && mideleg[sel_idx];
   end

endmodule

// File: rtl/priv_1_13_trap_arbiter.sv
// -----------------------------------------------------------------------------
// priv_1_13_trap_arbiter
// Collects interrupts and pipeline exceptions, applies enable/delegation
// rules, and runs a request/drain/commit handshake with the pipeline. The
// one-cycle trap pulse feeds the privilege-mode switcher and CSR trap entry.
// Ports:
//   CLK, nRST        clock, asynchronous active-low reset
//   curr_priv_level  current privilege (U=0, S=1, M=3)
//   mstatus_mie/sie  global M/S interrupt enables
//   mie, mideleg     per-interrupt enable and delegation masks
//   medeleg          exception delegation mask
//   irq_src          {meip, seip, mtip, stip, msip, ssip}, level-sensitive
//   ex_valid/cause   pipeline exception report
//   pipe_ready       pipeline drained to an instruction boundary
//   flush_req        drain/flush request to the pipeline
//   mip              registered pending-interrupt bits
//   trap             one-cycle trap commit pulse
//   trap_to_s        trap targets S-mode
//   trap_is_intr     1 = interrupt, 0 = exception
//   trap_cause       cause code of the committed trap
// -----------------------------------------------------------------------------
module priv_1_13_trap_arbiter
   import priv_1_13_trap_arbiter_pkg::*;
#(
   parameter int NUM_CAUSE_BITS = 5
) (
   input  logic                      CLK,
   input  logic                      nRST,
   input  logic [1:0]                curr_priv_level,
   input  logic                      mstatus_mie,
   input  logic                      mstatus_sie,
   input  logic [15:0]               mie,
   input  logic [15:0]               mideleg,
   input  logic [15:0]               medeleg,
   input  logic [5:0]                irq_src,
   input  logic                      ex_valid,
   input  logic [NUM_CAUSE_BITS-1:0] ex_cause,
   input  logic                      pipe_ready,
   output logic                      flush_req,
   output logic [15:0]               mip,
   output logic                      trap,
   output logic                      trap_to_s,
   output logic                      trap_is_intr,
   output logic [NUM_CAUSE_BITS-1:0] trap_cause
);

   arb_state_t                state_q, state_d;
   logic [15:0]               mip_q, mip_d;
   logic                      flush_req_q, flush_req_d;
   logic                      trap_q, trap_d;
   logic                      cap_to_s_q, cap_to_s_d;
   logic                      cap_is_intr_q, cap_is_intr_d;
   logic [NUM_CAUSE_BITS-1:0] cap_cause_q, cap_cause_d;

   logic [15:0]               intr_en;
   logic                      any_intr;
   logic [NUM_CAUSE_BITS-1:0] intr_cause;
   logic                      intr_to_s;
   logic                      ex_deleg;
   logic                      ex_to_s;
   logic                      cap_still_en;

   priv_1_13_intr_prio #(
      .NUM_CAUSE_BITS (NUM_CAUSE_BITS)
   ) u_intr_prio (
      .curr_priv_level (curr_priv_level),
      .mstatus_mie     (mstatus_mie),
      .mstatus_sie     (mstatus_sie),
      .mip             (mip_q),
      .mie             (mie),
      .mideleg         (mideleg),
      .intr_en         (intr_en),
      .any_intr        (any_intr),
      .intr_cause      (intr_cause),
      .intr_to_s       (intr_to_s)
   );

   // Exception causes beyond the 16-bit medeleg range are never delegated.
   // A captured interrupt is rechecked against the live enables before commit.
   always_comb begin
      ex_deleg     = (ex_cause < NUM_CAUSE_BITS'(16)) && medeleg[ex_cause[3:0]];
      ex_to_s      = ex_deleg && (priv_level_t'(curr_priv_level) != PRIV_M);
      cap_still_en = intr_en[cap_cause_q[3:0]];
   end

   // Next-state and capture logic. Outputs are derived from the next state so
   // that flush_req and trap come straight out of flops.
   always_comb begin
      state_d       = state_q;
      cap_to_s_d    = cap_to_s_q;
      cap_is_intr_d = cap_is_intr_q;
      cap_cause_d   = cap_cause_q;
      mip_d         = mip_from_irq(irq_src);

      case (state_q)
         ST_IDLE: begin
            if (ex_valid) begin
               cap_cause_d   = ex_cause;
               cap_to_s_d    = ex_to_s;
               cap_is_intr_d = 1'b0;
               state_d       = ST_WAIT;
            end else if (any_intr) begin
               cap_cause_d   = intr_cause;
               cap_to_s_d    = intr_to_s;
               cap_is_intr_d = 1'b1;
               state_d       = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // A late exception displaces a held interrupt; the drain restarts.
            if (ex_valid && cap_is_intr_q) begin
               cap_cause_d   = ex_cause;
               cap_to_s_d    = ex_to_s;
               cap_is_intr_d = 1'b0;
            end else if (pipe_ready) begin
               if (!cap_is_intr_q || cap_still_en) begin
                  state_d = ST_COMMIT;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_COMMIT: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      flush_req_d = (state_d != ST_IDLE);
      trap_d      = (state_d == ST_COMMIT);
   end

   // All state and registered outputs; reset drops everything to zero at once.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q       <= ST_IDLE;
         mip_q         <= 16'h0000;
         flush_req_q   <= 1'b0;
         trap_q        <= 1'b0;
         cap_to_s_q    <= 1'b0;
         cap_is_intr_q <= 1'b0;
         cap_cause_q   <= '0;
      end else begin
         state_q       <= state_d;
         mip_q         <= mip_d;
         flush_req_q   <= flush_req_d;
         trap_q        <= trap_d;
         cap_to_s_q    <= cap_to_s_d;
         cap_is_intr_q <= cap_is_intr_d;
         cap_cause_q   <= cap_cause_d;
      end
   end

   assign flush_req    = flush_req_q;
   assign mip          = mip_q;
   assign trap         = trap_q;
   assign trap_to_s    = cap_to_s_q;
   assign trap_is_intr = cap_is_intr_q;
   assign trap_cause   = cap_cause_q;

endmodule

// File: tb/tb_priv_1_13_trap_arbiter.sv
// -----------------------------------------------------------------------------
// tb_priv_1_13_trap_arbiter
// Directed testbench for the trap arbiter. Each task runs one scenario from
// a clean reset and compares outputs against hand-computed values. Inputs
// are driven and outputs sampled 1 time unit after the rising clock edge;
// "cycle N" refers to the interval following the Nth edge of a scenario.
// -----------------------------------------------------------------------------
module tb_priv_1_13_trap_arbiter;

   logic        clk;
   logic        n_rst;
   logic [1:0]  curr_priv_level;
   logic        mstatus_mie;
   logic        mstatus_sie;
   logic [15:0] mie;
   logic [15:0] mideleg;
   logic [15:0] medeleg;
   logic [5:0]  irq_src;
   logic        ex_valid;
   logic [4:0]  ex_cause;
   logic        pipe_ready;
   logic        flush_req;
   logic [15:0] mip;
   logic        trap;
   logic        trap_to_s;
   logic        trap_is_intr;
   logic [4:0]  trap_cause;

   int pass_cnt;
   int check_cnt;

   priv_1_13_trap_arbiter #(
      .NUM_CAUSE_BITS (5)
   ) dut (
      .CLK             (clk),
      .nRST            (n_rst),
      .curr_priv_level (curr_priv_level),
      .mstatus_mie     (mstatus_mie),
      .mstatus_sie     (mstatus_sie),
      .mie             (mie),
      .mideleg         (mideleg),
      .medeleg         (medeleg),
      .irq_src         (irq_src),
      .ex_valid        (ex_valid),
      .ex_cause        (ex_cause),
      .pipe_ready      (pipe_ready),
      .flush_req       (flush_req),
      .mip             (mip),
      .trap            (trap),
      .trap_to_s       (trap_to_s),
      .trap_is_intr    (trap_is_intr),
      .trap_cause      (trap_cause)
   );

   // Free-running core clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      curr_priv_level = 2'd0;
      mstatus_mie     = 1'b0;
      mstatus_sie     = 1'b0;
      mie             = 16'h0000;
      mideleg         = 16'h0000;
      medeleg         = 16'h0000;
      irq_src         = 6'b000000;
      ex_valid        = 1'b0;
      ex_cause        = 5'd0;
      pipe_ready      = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      n_rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_rst = 1'b1;
   endtask

   // Outputs must be zero while reset is held, even with every input active.
   task automatic test_reset();
      clear_inputs();
      n_rst      = 1'b0;
      irq_src    = 6'b111111;
      mie        = 16'hFFFF;
      ex_valid   = 1'b1;
      ex_cause   = 5'd4;
      pipe_ready = 1'b1;
      repeat (3) next_cycle();
      check_cnt++;
      if ({flush_req, mip, trap, trap_to_s, trap_is_intr, trap_cause} !== 25'd0)
         $display("[TB] FAIL reset_outputs: got %h expected 0",
                  {flush_req, mip, trap, trap_to_s, trap_is_intr, trap_cause});
      else pass_cnt++;
      n_rst = 1'b1;
   endtask

   // MTI at U-mode: irq in cycle 0, mip in 1, flush in 2, trap in 3.
   task automatic test_intr_latency();
      do_reset();
      mie        = 16'h0080;
      pipe_ready = 1'b1;
      irq_src    = 6'b001000;
      next_cycle();
      check_cnt++;
      if ({mip, flush_req, trap} !== {16'h0080, 1'b0, 1'b0})
         $display("[TB] FAIL lat_c1_mip: got mip=%h flush=%b trap=%b expected mip=0080 flush=0 trap=0", mip, flush_req, trap);
      else pass_cnt++;
      next_cycle();
      check_cnt++;
      if ({flush_req, trap} !== 2'b10)
         $display("[TB] FAIL lat_c2_flush: got flush=%b trap=%b expected flush=1 trap=0", flush_req, trap);
      else pass_cnt++;
      irq_src = 6'b000000;
      next_cycle();
      check_cnt++;
      if ({trap, trap_to_s, trap_is_intr, trap_cause} !== {1'b1, 1'b0, 1'b1, 5'd7})
         $display("[TB] FAIL lat_c3_trap: got trap=%b s=%b intr=%b cause=%0d expected 1 0 1 7", trap, trap_to_s, trap_is_intr, trap_cause);
      else pass_cnt++;
      next_cycle();
      check_cnt++;
      if ({trap, flush_req, trap_cause} !== {1'b0, 1'b0, 5'd7})
         $display("[TB] FAIL lat_c4_idle_hold: got trap=%b flush=%b cause=%0d expected 0 0 7", trap, flush_req, trap_cause);
      else pass_cnt++;
   endtask

   // MEI beats MTI; with MTI left pending a second trap follows with cause 7.
   task automatic test_intr_priority();
      do_reset();
      mie        = 16'h0880;
      pipe_ready = 1'b1;
      irq_src    = 6'b101000;
      next_cycle();
      check_cnt++;
      if (mip !== 16'h0880)
         $display("[TB] FAIL prio_mip: got %h expected 0880", mip);
      else pass_cnt++;
      next_cycle();
      irq_src = 6'b001000;
      next_cycle();
      check_cnt++;
      if ({trap, trap_is_intr, trap_cause} !== {1'b1, 1'b1, 5'd11})
         $display("[TB] FAIL prio_mei: got trap=%b intr=%b cause=%0d expected 1 1 11", trap, trap_is_intr, trap_cause);
      else pass_cnt++;
      next_cycle();
      check_cnt++;
      if (trap !== 1'b0)
         $display("[TB] FAIL prio_gap: got trap=%b expected 0", trap);
      else pass_cnt++;
      next_cycle();
      next_cycle();
      check_cnt++;
      if ({trap, trap_is_intr, trap_cause} !== {1'b1, 1'b1, 5'd7})
         $display("[TB] FAIL prio_mti_second: got trap=%b intr=%b cause=%0d expected 1 1 7", trap, trap_is_intr, trap_cause);
      else pass_cnt++;
      irq_src = 6'b000000;
   endtask

   // MSI outranks MTI, SEI and STI when all are pending and enabled.
   task automatic test_prio_msi();
      do_reset();
      mie        = 16'hFFFF;
      pipe_ready = 1'b1;
      irq_src    = 6'b011110;
      repeat (3) next_cycle();
      check_cnt++;
      if ({trap, trap_to_s, trap_cause} !== {1'b1, 1'b0, 5'd3})
         $display("[TB] FAIL prio_msi: got trap=%b s=%b cause=%0d expected 1 0 3", trap, trap_to_s, trap_cause);
      else pass_cnt++;
      irq_src = 6'b000000;
   endtask

   // Delegated exception: S-mode target from S, M-mode target from M.
   task automatic test_exc_deleg();
      do_reset();
      curr_priv_level = 2'd1;
      medeleg         = 16'h0004;
      pipe_ready      = 1'b1;
      ex_valid        = 1'b1;
      ex_cause        = 5'd2;
      next_cycle();
      check_cnt++;
      if ({flush_req, trap} !== 2'b10)
         $display("[TB] FAIL exc_s_wait: got flush=%b trap=%b expected 1 0", flush_req, trap);
      else pass_cnt++;
      ex_valid = 1'b0;
      next_cycle();
      check_cnt++;
      if ({trap, trap_to_s, trap_is_intr, trap_cause} !== {1'b1, 1'b1, 1'b0, 5'd2})
         $display("[TB] FAIL exc_s_trap: got trap=%b s=%b intr=%b cause=%0d expected 1 1 0 2", trap, trap_to_s, trap_is_intr, trap_cause);
      else pass_cnt++;
      next_cycle();
      curr_priv_level = 2'd3;
      ex_valid        = 1'b1;
      next_cycle();
      ex_valid = 1'b0;
      next_cycle();
      check_cnt++;
      if ({trap, trap_to_s, trap_is_intr, trap_cause} !== {1'b1, 1'b0, 1'b0, 5'd2})
         $display("[TB] FAIL exc_m_trap: got trap=%b s=%b intr=%b cause=%0d expected 1 0 0 2", trap, trap_to_s, trap_is_intr, trap_cause);
      else pass_cnt++;
   endtask

   // Delegated SEI while in M-mode must never be taken.
   task automatic test_m_deleg_masked();
      do_reset();
      curr_priv_level = 2'd3;
      mstatus_mie     = 1'b1;
      mstatus_sie     = 1'b1;
      mideleg         = 16'h0200;
      mie             = 16'h0200;
      pipe_ready      = 1'b1;
      irq_src         = 6'b010000;
      next_cycle();
      check_cnt++;
      if (mip !== 16'h0200)
         $display("[TB] FAIL mdeleg_mip: got %h expected 0200", mip);
      else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         check_cnt++;
         if ({flush_req, trap} !== 2'b00)
            $display("[TB] FAIL mdeleg_quiet: got flush=%b trap=%b expected 0 0 (cycle %0d)", flush_req, trap, i + 2);
         else pass_cnt++;
      end
      irq_src = 6'b000000;
   endtask

   // In M-mode an M-targeted interrupt waits for mstatus.MIE.
   task automatic test_mie_gate();
      do_reset();
      curr_priv_level = 2'd3;
      mie             = 16'h0080;
      pipe_ready      = 1'b1;
      irq_src         = 6'b001000;
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         check_cnt++;
         if ({flush_req, trap} !== 2'b00)
            $display("[TB] FAIL mie_gate_off: got flush=%b trap=%b expected 0 0", flush_req, trap);
         else pass_cnt++;
      end
      mstatus_mie = 1'b1;
      next_cycle();
      next_cycle();
      check_cnt++;
      if ({trap, trap_to_s, trap_cause} !== {1'b1, 1'b0, 5'd7})
         $display("[TB] FAIL mie_gate_on: got trap=%b s=%b cause=%0d expected 1 0 7", trap, trap_to_s, trap_cause);
      else pass_cnt++;
      irq_src = 6'b000000;
   endtask

   // Delegated STI from S-mode with SIE set targets S.
   task automatic test_s_deleg_intr();
      do_reset();
      curr_priv_level = 2'd1;
      mstatus_sie     = 1'b1;
      mideleg         = 16'h0020;
      mie             = 16'h0020;
      pipe_ready      = 1'b1;
      irq_src         = 6'b000100;
      repeat (3) next_cycle();
      check_cnt++;
      if ({trap, trap_to_s, trap_is_intr, trap_cause} !== {1'b1, 1'b1, 1'b1, 5'd5})
         $display("[TB] FAIL sdeleg_trap: got trap=%b s=%b intr=%b cause=%0d expected 1 1 1 5", trap, trap_to_s, trap_is_intr, trap_cause);
      else pass_cnt++;
      irq_src = 6'b000000;
   endtask

   // Exception arriving in WAIT displaces the held interrupt; one trap only.
   task automatic test_ex_preempts_intr();
      do_reset();
      mie     = 16'h0080;
      irq_src = 6'b001000;
      next_cycle();
      next_cycle();
      check_cnt++;
      if (flush_req !== 1'b1)
         $display("[TB] FAIL preempt_wait: got flush=%b expected 1", flush_req);
      else pass_cnt++;
      ex_valid = 1'b1;
      ex_cause = 5'd8;
      next_cycle();
      ex_valid = 1'b0;
      check_cnt++;
      if ({flush_req, trap} !== 2'b10)
         $display("[TB] FAIL preempt_hold: got flush=%b trap=%b expected 1 0", flush_req, trap);
      else pass_cnt++;
      next_cycle();
      pipe_ready = 1'b1;
      irq_src    = 6'b000000;
      next_cycle();
      check_cnt++;
      if ({trap, trap_to_s, trap_is_intr, trap_cause} !== {1'b1, 1'b0, 1'b0, 5'd8})
         $display("[TB] FAIL preempt_trap: got trap=%b s=%b intr=%b cause=%0d expected 1 0 0 8", trap, trap_to_s, trap_is_intr, trap_cause);
      else pass_cnt++;
      for (int i = 0; i < 2; i++) begin
         next_cycle();
         check_cnt++;
         if ({flush_req, trap} !== 2'b00)
            $display("[TB] FAIL preempt_single: got flush=%b trap=%b expected 0 0", flush_req, trap);
         else pass_cnt++;
      end
   endtask

   // Interrupt withdrawn before pipe_ready: abandon without a trap.
   task automatic test_intr_withdrawn();
      do_reset();
      mie     = 16'h0080;
      irq_src = 6'b001000;
      next_cycle();
      next_cycle();
      irq_src = 6'b000000;
      next_cycle();
      pipe_ready = 1'b1;
      check_cnt++;
      if ({flush_req, mip} !== {1'b1, 16'h0000})
         $display("[TB] FAIL withdraw_wait: got flush=%b mip=%h expected 1 0000", flush_req, mip);
      else pass_cnt++;
      for (int i = 0; i < 2; i++) begin
         next_cycle();
         check_cnt++;
         if ({flush_req, trap} !== 2'b00)
            $display("[TB] FAIL withdraw_idle: got flush=%b trap=%b expected 0 0", flush_req, trap);
         else pass_cnt++;
      end
   endtask

   // Asynchronous reset in WAIT clears every output without a clock edge.
   task automatic test_reset_in_wait();
      do_reset();
      mie     = 16'h0800;
      irq_src = 6'b100000;
      next_cycle();
      next_cycle();
      check_cnt++;
      if ({flush_req, trap_cause} !== {1'b1, 5'd11})
         $display("[TB] FAIL rstwait_pre: got flush=%b cause=%0d expected 1 11", flush_req, trap_cause);
      else pass_cnt++;
      #2;
      n_rst = 1'b0;
      #1;
      check_cnt++;
      if ({flush_req, mip, trap, trap_to_s, trap_is_intr, trap_cause} !== 25'd0)
         $display("[TB] FAIL rstwait_async: got %h expected 0",
                  {flush_req, mip, trap, trap_to_s, trap_is_intr, trap_cause});
      else pass_cnt++;
      irq_src    = 6'b000000;
      pipe_ready = 1'b1;
      next_cycle();
      n_rst = 1'b1;
      next_cycle();
      check_cnt++;
      if ({flush_req, trap, mip} !== {1'b0, 1'b0, 16'h0000})
         $display("[TB] FAIL rstwait_after: got flush=%b trap=%b mip=%h expected 0 0 0000", flush_req, trap, mip);
      else pass_cnt++;
   endtask

   // Scenario sequence followed by the single summary line.
   initial begin
      pass_cnt  = 0;
      check_cnt = 0;
      n_rst     = 1'b0;
      clear_inputs();
      $display("[TB] starting trap arbiter scenarios");
      test_reset();
      test_intr_latency();
      test_intr_priority();
      test_prio_msi();
      test_exc_deleg();
      test_m_deleg_masked();
      test_mie_gate();
      test_s_deleg_intr();
      test_ex_preempts_intr();
      test_intr_withdrawn();
      test_reset_in_wait();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
